// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared definitions for the MEM-stage data cache: controller
//                state encoding, default geometry and address-field widths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

   localparam int C_LINES          = 64;
   localparam int C_WORDS_PER_LINE = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WTHRU  = 2'd2
   } state_t;

   // Width of the line-index field.
   function automatic int idx_width(input int lines);
      return $clog2(lines);
   endfunction

   // Width of the word-offset field.
   function automatic int off_width(input int words);
      return $clog2(words);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_tag_array.sv
// ============================================================================
//  Module      : dcache_tag_array
//  Description : Valid bits plus tag RAM for the direct-mapped data cache.
//                Valid bits clear asynchronously; the tag RAM is not reset.
//                One write port (marks the line valid with the new tag) and a
//                combinational hit output for the presented index/tag.
//  Ports       : clk, rst_n      clock, async active-low reset
//                idx, tag        lookup / write address fields
//                we              write tag and set valid for idx
//                hit             valid[idx] && tag_arr[idx] == tag
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_tag_array
   import cache_pkg::*;
#(
   parameter int LINES = C_LINES,
   parameter int TAG_W = 22,
   parameter int IDX_W = idx_width(LINES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx,
   input  logic [TAG_W-1:0] tag,
   input  logic             we,
   output logic             hit
);

   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag [LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (we) begin
         r_valid[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         r_tag[idx] <= tag;
      end
   end

   assign hit = r_valid[idx] && (r_tag[idx] == tag);

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
//  Module      : dcache_ctrl
//  Description : MEM-stage data-cache controller. Direct-mapped, write-through,
//                no-write-allocate. Serves load hits combinationally, refills
//                whole lines on a load miss and issues one write beat per store
//                over a word-wide memory handshake. Mem_Stall freezes the
//                pipeline while an access is outstanding.
//  Ports       : clk, rst_n           clock, async active-low reset
//                MemReadM, MemWriteM  load / store in MEM stage
//                ALUoutM, RD2M        byte address, store data
//                ReadDataM            load data (valid when not stalled)
//                Mem_Stall            combinational stall request
//                mem_req, mem_we      memory beat request / write beat
//                mem_addr, mem_wdata  word-aligned beat address, write data
//                mem_ready, mem_rdata beat complete, read-beat data
//                hit_cnt, miss_cnt    read hit / miss counters (optional)
//  Config      : DCACHE_STATS_EN adds the hit_cnt/miss_cnt counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int LINES          = C_LINES,
   parameter int WORDS_PER_LINE = C_WORDS_PER_LINE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] RD2M,
   output logic [31:0] ReadDataM,
   output logic        Mem_Stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int IDX_W = idx_width(LINES);
   localparam int OFF_W = off_width(WORDS_PER_LINE);
   localparam int TAG_W = 30 - IDX_W - OFF_W;
   localparam logic [OFF_W-1:0] C_BEAT_LAST = '1;
   localparam logic [OFF_W-1:0] C_BEAT_ONE  = OFF_W'(1);

   state_t             r_state;
   logic [OFF_W-1:0]   r_beat;
   logic               r_mem_req;
   logic               r_mem_we;

   logic [31:0]        r_data [LINES*WORDS_PER_LINE];

   logic [OFF_W-1:0]   w_off;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic               w_idle;
   logic               w_rd_req;
   logic               w_rd_hit;
   logic               w_last_beat;
   logic               w_data_we;
   logic [IDX_W+OFF_W-1:0] w_data_waddr;
   logic [31:0]        w_data_wdata;
   logic               w_unused_addr;

   assign w_off = ALUoutM[OFF_W+1:2];
   assign w_idx = ALUoutM[OFF_W+IDX_W+1:OFF_W+2];
   assign w_tag = ALUoutM[31:OFF_W+IDX_W+2];
   assign w_unused_addr = ^ALUoutM[1:0];

   // A simultaneous store request overrides the load.
   assign w_idle      = (r_state == IDLE);
   assign w_rd_req    = MemReadM && !MemWriteM;
   assign w_rd_hit    = w_idle && w_rd_req && w_hit;
   assign w_last_beat = (r_state == REFILL) && mem_ready && (r_beat == C_BEAT_LAST);

   // The line becomes valid only once its final word has arrived.
   dcache_tag_array #(
      .LINES (LINES),
      .TAG_W (TAG_W),
      .IDX_W (IDX_W)
   ) u_tags (
      .clk   (clk),
      .rst_n (rst_n),
      .idx   (w_idx),
      .tag   (w_tag),
      .we    (w_last_beat),
      .hit   (w_hit)
   );

   // Data array write: refill beats, or a store that hits the resident line.
   always_comb begin
      w_data_we    = 1'b0;
      w_data_waddr = {w_idx, w_off};
      w_data_wdata = RD2M;
      if ((r_state == REFILL) && mem_ready) begin
         w_data_we    = 1'b1;
         w_data_waddr = {w_idx, r_beat};
         w_data_wdata = mem_rdata;
      end else if ((r_state == WTHRU) && mem_ready && w_hit) begin
         w_data_we    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_data_we) begin
         r_data[w_data_waddr] <= w_data_wdata;
      end
   end

   // Controller FSM with registered memory-request outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (MemWriteM) begin
                  r_state   <= WTHRU;
                  r_mem_req <= 1'b1;
                  r_mem_we  <= 1'b1;
               end else if (MemReadM && !w_hit) begin
                  r_state   <= REFILL;
                  r_beat    <= '0;
                  r_mem_req <= 1'b1;
                  r_mem_we  <= 1'b0;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  r_beat <= r_beat + C_BEAT_ONE;
                  if (r_beat == C_BEAT_LAST) begin
                     r_state   <= IDLE;
                     r_mem_req <= 1'b0;
                  end
               end
            end
            WTHRU: begin
               if (mem_ready) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   // Stall is released in IDLE on a hit, and in WTHRU as the beat completes.
   always_comb begin
      Mem_Stall = 1'b1;
      case (r_state)
         IDLE:    Mem_Stall = MemWriteM || (MemReadM && !w_hit);
         REFILL:  Mem_Stall = 1'b1;
         WTHRU:   Mem_Stall = !mem_ready;
         default: Mem_Stall = 1'b1;
      endcase
   end

   assign ReadDataM = w_rd_hit ? r_data[{w_idx, w_off}] : 32'h0;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = (r_state == REFILL) ? {w_tag, w_idx, r_beat, 2'b00}
                                          : {ALUoutM[31:2], 2'b00};
   assign mem_wdata = RD2M;

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        r_post_refill;

   // The hit that completes a refilled load belongs to the miss already counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt     <= '0;
         r_miss_cnt    <= '0;
         r_post_refill <= 1'b0;
      end else begin
         r_post_refill <= w_last_beat;
         if (w_rd_hit && !r_post_refill) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_idle && w_rd_req && !w_hit) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Self-checking bench for dcache_ctrl (LINES=64, W=4). Expected
//                memory beats and load data are queued as stimulus is driven
//                and compared as the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemReadM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [31:0] ALUoutM = 32'h0;
   logic [31:0] RD2M = 32'h0;
   logic [31:0] ReadDataM;
   logic        Mem_Stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int lat = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   beat_t       beat_q[$];
   logic [31:0] rdata_q[$];
   logic [31:0] mem_model [bit [31:0]];

   dcache_ctrl u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MemReadM  (MemReadM),
      .MemWriteM (MemWriteM),
      .ALUoutM   (ALUoutM),
      .RD2M      (RD2M),
      .ReadDataM (ReadDataM),
      .Mem_Stall (Mem_Stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Backing memory: stored words, otherwise an address-derived pattern.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic run_load(input logic [31:0] addr, input int exp_beats);
      int    beats = 0;
      int    waited = 0;
      bit    done = 0;
      beat_t bt;
      logic [31:0] exp_rd;
      for (int b = 0; b < exp_beats; b++) begin
         bt.we    = 1'b0;
         bt.addr  = {addr[31:4], b[1:0], 2'b00};
         bt.wdata = 32'h0;
         beat_q.push_back(bt);
      end
      rdata_q.push_back(mem_word({addr[31:2], 2'b00}));
      @(posedge clk); #1;
      MemReadM = 1'b1;
      ALUoutM  = addr;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge clk);
         if (!Mem_Stall) begin
            exp_rd = rdata_q.pop_front();
            checks++;
            if (ReadDataM !== exp_rd) begin
               errors++;
               $display("FAIL load_data addr=%h got=%h exp=%h", addr, ReadDataM, exp_rd);
            end
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL hit_no_req addr=%h got=%b exp=0", addr, mem_req);
            end
            done = 1;
         end else if (mem_req) begin
            if (waited < lat) begin
               waited++;
            end else begin
               checks++;
               if (beat_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat addr=%h got=%h exp=none", addr, mem_addr);
               end else begin
                  bt = beat_q.pop_front();
                  if (mem_we !== bt.we || mem_addr !== bt.addr) begin
                     errors++;
                     $display("FAIL refill_beat got we=%b addr=%h exp we=%b addr=%h",
                              mem_we, mem_addr, bt.we, bt.addr);
                  end
               end
               mem_rdata = mem_word(mem_addr);
               mem_ready = 1'b1;
               beats++;
               @(posedge clk); #1;
               mem_ready = 1'b0;
               waited = 0;
            end
         end else if (beats > 0) begin
            checks++;
            errors++;
            $display("FAIL req_dropped addr=%h got=0 exp=1", addr);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL load_timeout addr=%h got=stalled exp=released", addr);
         rdata_q.delete();
      end
      checks++;
      if (beats != exp_beats) begin
         errors++;
         $display("FAIL beat_count addr=%h got=%0d exp=%0d", addr, beats, exp_beats);
      end
      beat_q.delete();
      @(posedge clk); #1;
      MemReadM = 1'b0;
   endtask

   task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                            input int wait_cycles);
      int    waited = 0;
      bit    done = 0;
      beat_t bt;
      bt.we    = 1'b1;
      bt.addr  = {addr[31:2], 2'b00};
      bt.wdata = data;
      beat_q.push_back(bt);
      @(posedge clk); #1;
      MemWriteM = 1'b1;
      ALUoutM   = addr;
      RD2M      = data;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge clk);
         if (mem_req) begin
            if (waited < wait_cycles) begin
               checks++;
               if (Mem_Stall !== 1'b1 || mem_we !== 1'b1 ||
                   mem_addr !== beat_q[0].addr || mem_wdata !== beat_q[0].wdata) begin
                  errors++;
                  $display("FAIL wthru_hold cyc=%0d got stall=%b we=%b addr=%h wdata=%h exp stall=1 we=1 addr=%h wdata=%h",
                           waited, Mem_Stall, mem_we, mem_addr, mem_wdata,
                           beat_q[0].addr, beat_q[0].wdata);
               end
               waited++;
            end else begin
               bt = beat_q.pop_front();
               checks++;
               if (mem_we !== bt.we || mem_addr !== bt.addr || mem_wdata !== bt.wdata) begin
                  errors++;
                  $display("FAIL store_beat got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                           mem_we, mem_addr, mem_wdata, bt.we, bt.addr, bt.wdata);
               end
               mem_ready = 1'b1;
               #1;
               checks++;
               if (Mem_Stall !== 1'b0) begin
                  errors++;
                  $display("FAIL store_release addr=%h got=%b exp=0", addr, Mem_Stall);
               end
               mem_model[bt.addr] = bt.wdata;
               done = 1;
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL store_timeout addr=%h got=no_beat exp=beat", addr);
      end
      beat_q.delete();
      @(posedge clk); #1;
      mem_ready = 1'b0;
      MemWriteM = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || Mem_Stall !== 1'b0) begin
         errors++;
         $display("FAIL store_idle got req=%b stall=%b exp req=0 stall=0", mem_req, Mem_Stall);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || Mem_Stall !== 1'b0 || ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL reset_idle got req=%b we=%b stall=%b rd=%h exp 0 0 0 0",
                  mem_req, mem_we, Mem_Stall, ReadDataM);
      end
      MemReadM = 1'b1;
      ALUoutM  = 32'h0000_1008;
      #1;
      checks++;
      if (Mem_Stall !== 1'b1 || ReadDataM !== 32'h0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_load got stall=%b rd=%h req=%b exp stall=1 rd=0 req=0",
                  Mem_Stall, ReadDataM, mem_req);
      end
      MemReadM = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read_miss_hit();
      run_load(32'h0000_1008, 4);
      run_load(32'h0000_1000, 0);
   endtask

   task automatic test_store_hit();
      run_store(32'h0000_1004, 32'hDEAD_BEEF, 0);
      run_load(32'h0000_1004, 0);
`ifdef DCACHE_STATS_EN
      checks++;
      if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
         errors++;
         $display("FAIL stats got hit=%0d miss=%0d exp hit=2 miss=1", hit_cnt, miss_cnt);
      end
`endif
   endtask

   task automatic test_store_miss();
      run_store(32'h0000_2000, 32'h1234_5678, 0);
      run_load(32'h0000_2000, 4);
   endtask

   task automatic test_conflict();
      lat = 1;
      run_load(32'h0000_1000, 4);
      run_load(32'h0000_1000, 0);
      run_load(32'h0000_1400, 4);
      run_load(32'h0000_1000, 4);
      lat = 0;
   endtask

   task automatic test_reset_mid_refill();
      int beats = 0;
      @(posedge clk); #1;
      MemReadM = 1'b1;
      ALUoutM  = 32'h0000_5040;
      for (int cyc = 0; cyc < 50 && beats < 2; cyc++) begin
         @(negedge clk);
         if (mem_req) begin
            mem_rdata = mem_word(mem_addr);
            mem_ready = 1'b1;
            beats++;
            @(posedge clk); #1;
            mem_ready = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5048) begin
         errors++;
         $display("FAIL beat2_addr got req=%b addr=%h exp req=1 addr=00005048", mem_req, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_req got req=%b we=%b exp 0 0", mem_req, mem_we);
      end
      checks++;
      if (Mem_Stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_stall got=%b exp=1", Mem_Stall);
      end
      @(posedge clk); #1;
      MemReadM = 1'b0;
      #2;
      rst_n = 1'b1;
      run_load(32'h0000_5040, 4);
      run_load(32'h0000_1008, 4);
   endtask

   task automatic test_wthru_wait();
      run_store(32'h0000_1008, 32'hCAFE_F00D, 10);
      run_load(32'h0000_1008, 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      logic [31:0] exp_rd;
      addrs[0] = 32'h0000_1000;
      addrs[1] = 32'h0000_1004;
      addrs[2] = 32'h0000_100C;
      @(posedge clk); #1;
      MemReadM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ALUoutM = addrs[i];
         rdata_q.push_back(mem_word(addrs[i]));
         @(negedge clk);
         exp_rd = rdata_q.pop_front();
         checks++;
         if (Mem_Stall !== 1'b0 || ReadDataM !== exp_rd) begin
            errors++;
            $display("FAIL b2b_hit addr=%h got stall=%b rd=%h exp stall=0 rd=%h",
                     addrs[i], Mem_Stall, ReadDataM, exp_rd);
         end
         @(posedge clk); #1;
      end
      MemReadM = 1'b0;
      #1;
      checks++;
      if (Mem_Stall !== 1'b0 || mem_req !== 1'b0 || ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL no_access got stall=%b req=%b rd=%h exp 0 0 0", Mem_Stall, mem_req, ReadDataM);
      end
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_reset_mid_refill();
      test_wthru_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
